tmr_irq_ctrl: RTL
=================

Name: tmr_irq_ctrl

Overview:
- Interrupt/event controller directly downstream of the 8-bit timer IP.
- Consumes the timer's TMR_OVF / TMR_UDF flags, edge-detects them, and latches them into W1C status bits with overrun tracking.
- Gates the status with enable bits and drives a single TMR_IRQ line to the system interrupt controller.
- Programmed over its own 8-bit-data APB slave port on the same PCLK domain as the timer.

Parameters:
- ADDR_WIDTH, 8, APB address width; only the low 3 bits are decoded, all higher bits must be 0.
- DATA_WIDTH, 8, APB data width; registers are 8 bits wide.

Ports:
- PCLK  in  1  system/APB clock; single clock domain.
- PRESET  in  1  synchronous, active-high reset, sampled on PCLK rising edge.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  register byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error on unmapped address.
- TMR_OVF  in  1  timer overflow flag (level, synchronous to PCLK).
- TMR_UDF  in  1  timer underflow flag (level, synchronous to PCLK).
- TMR_IRQ  out  1  interrupt request to the system.

Behaviour:
- Reset: all registers = 0x00; edge-detect flops = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0; TMR_IRQ = 0.
- Because the edge-detect flops reset to 0, a flag already high at reset release is captured as an event on the first cycle after reset.
- APB:
  - Zero wait-state. PREADY = PSEL & PENABLE, combinational.
  - Writes commit at the PCLK edge where PSEL & PENABLE & PWRITE = 1.
  - PRDATA is combinational during PSEL & PENABLE & ~PWRITE, and 0x00 otherwise.
  - PSLVERR = PSEL & PENABLE & (unmapped address). Unmapped writes are ignored; unmapped reads return 0x00.
- Register map:
  - 0x00 IRQ_EN, RW: bit0 OVF_EN, bit1 UDF_EN; bits[7:2] read 0, writes to them ignored.
  - 0x01 IRQ_STS, W1C: bit0 OVF, bit1 UDF, bit2 OVF_OVR, bit3 UDF_OVR. Writing 1 clears the bit; writing 0 leaves it unchanged.
  - 0x02 IRQ_RAW, RO: bit0 = TMR_OVF, bit1 = TMR_UDF (live levels). Writes are ignored, no error.
  - 0x03 IRQ_CFG, RW: bit0 PULSE_MODE (0 = level IRQ, 1 = one-cycle pulse).
  - 0x04/0x05: counters, see Optional Feature. All other addresses are unmapped.
- Event detect: ovf_evt = TMR_OVF & ~ovf_q, where ovf_q is TMR_OVF registered each cycle. UDF is handled identically.
- Status update per cycle, per channel:
  - evt & STS.x == 1 sets x_OVR.
  - evt sets x.
  - A same-cycle W1C of x and evt: set wins, so x stays 1 and OVR is not set.
  - A same-cycle W1C of x_OVR and an overrun: set wins.
- Event status latches regardless of the enable bit; enable only gates the IRQ.
- IRQ:
  - pend = (STS.OVF & OVF_EN) | (STS.UDF & UDF_EN).
  - Level mode: TMR_IRQ = pend, registered. Latency is 2 PCLK from the flag rising edge to TMR_IRQ = 1, and 1 PCLK from the W1C write edge to TMR_IRQ = 0.
  - Pulse mode: TMR_IRQ = 1 for exactly one cycle when pend rises (pend & ~pend_q), registered. Clearing and re-setting status produces a new pulse.
  - Changing PULSE_MODE takes effect the next cycle; no pulse is generated by the mode change itself.
  - Enabling a bit whose status is already 1 raises pend immediately: level mode asserts IRQ 1 cycle later; pulse mode pulses if pend was 0.
- Reset mid-operation returns all state to reset values on that edge; an in-flight APB transfer is abandoned (PREADY = 0).

Optional Feature:
- Macro TMR_IRQ_EVCNT_EN.
- Defined:
  - 0x04 OVF_CNT and 0x05 UDF_CNT, RO, 8-bit event counters.
  - Each increments on its ovf_evt/udf_evt and saturates at 0xFF.
  - Any write to the counter's address clears it to 0x00, no error. A clear in the same cycle as an event yields 0x01.
  - Both reset to 0x00.
- Not defined: no counter logic is built; 0x04/0x05 are unmapped (PSLVERR = 1, read 0x00).

Test Plan:
- Reset, then read 0x00–0x03 -> all 0x00, PSLVERR = 0; read 0x06 -> PRDATA 0x00, PSLVERR = 1.
- Write IRQ_EN = 0x01, then pulse TMR_OVF high for 3 cycles -> STS = 0x01, TMR_IRQ rises 2 cycles after the TMR_OVF edge; write STS = 0x01 -> TMR_IRQ = 0 next cycle, STS = 0x00.
- With EN = 0x00, toggle TMR_UDF twice with no clear in between -> STS = 0x0A, TMR_IRQ stays 0; then write EN = 0x02 -> TMR_IRQ = 1 one cycle later.
- CFG = 0x01, EN = 0x03, OVF event -> TMR_IRQ high exactly 1 cycle; a UDF event while OVF is still pending -> no new pulse; clear STS = 0x0F, then an OVF event -> new 1-cycle pulse.
- TMR_OVF rising edge in the same cycle as a W1C write of 0x01 to STS -> STS.OVF stays 1 and OVF_OVR stays 0.
- With TMR_IRQ_EVCNT_EN: 300 OVF edges -> OVF_CNT = 0xFF; write 0x04 -> reads 0x00; UDF_CNT unaffected. Without the macro: read 0x04 -> PSLVERR = 1.

Source files
------------

// File: rtl/tmr_irq_ctrl.sv
// Timer interrupt controller: edge-detects TMR_OVF/TMR_UDF into W1C status with
// overrun tracking, gates with enables and drives TMR_IRQ. Build macro: TMR_IRQ_EVCNT_EN adds event counters.
module tmr_irq_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic                  TMR_OVF,
    input  logic                  TMR_UDF,
    output logic                  TMR_IRQ
);

    localparam int unsigned REG_W = 8;
    localparam int unsigned LO_W  = 3;

    localparam logic [LO_W-1:0] A_EN   = 3'd0;
    localparam logic [LO_W-1:0] A_STS  = 3'd1;
    localparam logic [LO_W-1:0] A_RAW  = 3'd2;
    localparam logic [LO_W-1:0] A_CFG  = 3'd3;
    localparam logic [LO_W-1:0] A_OCNT = 3'd4;
    localparam logic [LO_W-1:0] A_UCNT = 3'd5;

    logic [1:0] flag_q, flag_d;
    logic [1:0] en_q, en_d;
    logic [3:0] sts_q, sts_d;
    logic       cfg_q, cfg_d;
    logic       pend_q, pend_d;
    logic       irq_q, irq_d;

    logic [LO_W-1:0]  addr_lo;
    logic             addr_hi_ok;
    logic             mapped;
    logic             acc;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       evt;
    logic [1:0]       ovr_set;
    logic [3:0]       clr;
    logic [REG_W-1:0] rdata;
    logic             unused_wdata;

    assign addr_lo      = PADDR[LO_W-1:0];
    assign addr_hi_ok   = (PADDR >> LO_W) == ADDR_WIDTH'(0);
    assign unused_wdata = ^PWDATA[DATA_WIDTH-1:4];

    // Transfers are dropped while reset is held so nothing completes mid-reset
    assign acc   = PSEL & PENABLE & ~PRESET;
    assign wr_en = acc & PWRITE & mapped;
    assign rd_en = acc & ~PWRITE & mapped;

`ifdef TMR_IRQ_EVCNT_EN
    logic [REG_W-1:0] cnt_q [2];
    logic [REG_W-1:0] cnt_d [2];
    logic [1:0]       cnt_clr;
`endif

    always_comb begin
        mapped = 1'b0;
        if (addr_hi_ok) begin
            case (addr_lo)
                A_EN, A_STS, A_RAW, A_CFG: mapped = 1'b1;
`ifdef TMR_IRQ_EVCNT_EN
                A_OCNT, A_UCNT:            mapped = 1'b1;
`endif
                default:                   mapped = 1'b0;
            endcase
        end
    end

    // Status, enables, config and IRQ generation
    always_comb begin
        flag_d  = {TMR_UDF, TMR_OVF};
        evt     = flag_d & ~flag_q;
        clr     = (wr_en && addr_lo == A_STS) ? PWDATA[3:0] : 4'b0000;
        // A clear racing a new event means the event replaces it rather than overrunning
        ovr_set = evt & sts_q[1:0] & ~clr[1:0];
        sts_d   = {ovr_set | (sts_q[3:2] & ~clr[3:2]), evt | (sts_q[1:0] & ~clr[1:0])};
        en_d    = (wr_en && addr_lo == A_EN) ? PWDATA[1:0] : en_q;
        cfg_d   = (wr_en && addr_lo == A_CFG) ? PWDATA[0] : cfg_q;
        pend_d  = |(sts_q[1:0] & en_q);
        irq_d   = cfg_q ? (pend_d & ~pend_q) : pend_d;
    end

`ifdef TMR_IRQ_EVCNT_EN
    // Saturating event counters; a clear coinciding with an event leaves a count of one
    always_comb begin
        cnt_clr[0] = wr_en && addr_lo == A_OCNT;
        cnt_clr[1] = wr_en && addr_lo == A_UCNT;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr[i]) begin
                cnt_d[i] = REG_W'(evt[i]);
            end else if (evt[i] && cnt_q[i] != 8'hFF) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        rdata = 8'h00;
        case (addr_lo)
            A_EN:    rdata = {6'b0, en_q};
            A_STS:   rdata = {4'b0, sts_q};
            A_RAW:   rdata = {6'b0, TMR_UDF, TMR_OVF};
            A_CFG:   rdata = {7'b0, cfg_q};
`ifdef TMR_IRQ_EVCNT_EN
            A_OCNT:  rdata = cnt_q[0];
            A_UCNT:  rdata = cnt_q[1];
`endif
            default: rdata = 8'h00;
        endcase
    end

    assign PRDATA  = rd_en ? DATA_WIDTH'(rdata) : DATA_WIDTH'(0);
    assign PREADY  = acc;
    assign PSLVERR = acc & ~mapped;
    assign TMR_IRQ = irq_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            flag_q <= 2'b00;
            en_q   <= 2'b00;
            sts_q  <= 4'h0;
            cfg_q  <= 1'b0;
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            en_q   <= en_d;
            sts_q  <= sts_d;
            cfg_q  <= cfg_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

`ifdef TMR_IRQ_EVCNT_EN
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (PRESET) begin
                cnt_q[i] <= 8'h00;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

endmodule
